seq_scan_scheduler: RTL and testbench
=====================================

Name: seq_scan_scheduler

Overview:
- Shared serial pattern-scan engine with a 4-requester round-robin scheduler in front of it.
- Each granted requester's DW-bit word is shifted MSB-first through an internal Moore non-overlapping "1001" detector (states A/B/C/D/E).
- The number of matches is returned to that requester with a one-cycle completion pulse.
- Sits between up to four producer blocks and a single detector resource, so the detector is time-shared instead of replicated.

Parameters:
- DW, 8, bits per scanned word (≥4).
- CW, 4, width of match_cnt; count saturates at 2^CW-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- req  input  4  per-requester scan request, level; held until own gnt bit seen
- req_data  input  4*DW  requester i word at bits [i*DW +: DW]; stable while req[i]=1
- gnt  output  4  one-hot, single-cycle grant acknowledge
- busy  output  1  1 while a word is being scanned (SHIFT or DONE)
- done  output  1  single-cycle completion pulse
- done_id  output  2  index of requester whose result is on match_cnt
- match_cnt  output  CW  matches found in last completed word
- hit  output  1  match_cnt != 0, registered with match_cnt

Behaviour:
- Reset (rst=0, async): state IDLE; gnt=0, busy=0, done=0, done_id=0, match_cnt=0, hit=0; detector state A; bit counter 0; round-robin last-grant pointer=3, so requester 0 has highest priority first.
- Scheduler FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - if req==0, stay.
  - else select the first set req bit searching last+1, last+2, ... (mod 4).
  - on the clock edge: capture that requester's word into the shift register; pointer←selected; gnt←onehot(selected); detector←A; match count←0; bit counter←DW-1; state→SHIFT.
- SHIFT:
  - gnt is high only in the first SHIFT cycle.
  - Each cycle, the current MSB feeds the detector and the register shifts left.
  - Detector transitions on bit x:
    - A: 0→A, 1→B
    - B: 0→C, 1→B
    - C: 0→D, 1→B
    - D: 0→A, 1→E
    - E: 0→A, 1→B (non-overlapping)
  - Count increments (saturating) on every entry into E.
  - After the DW-th bit (counter==0), state→DONE.
- DONE: for one cycle, done=1, done_id=granted index, match_cnt/hit updated with the final count (including a match on the last bit); state→IDLE.
- match_cnt, hit and done_id hold until the next done.
- Timing, with req sampled high in IDLE cycle T:
  - gnt at T+1
  - done at T+1+DW
  - IDLE again at T+2+DW
  - back-to-back job period is DW+2 cycles.
- req changes during SHIFT/DONE are ignored; a request is only evaluated in IDLE.
- A requester that drops req before grant simply loses its turn, and the pointer is unchanged.
- busy=1 in SHIFT and DONE.
- Reset asserted mid-SHIFT aborts the job: no done, outputs return to reset values, and the aborted requester must re-request.

Test Plan:
- req=0001, data0=8'b10011001 -> gnt=0001 at T+1, done at T+9, done_id=0, match_cnt=2, hit=1.
- req=0010, data1=8'b10010010 -> match_cnt=1. An overlapping detector would give 2, so this checks non-overlap.
- req=1111 held from reset, all data=8'h00 -> grants in order 0001, 0010, 0100, 1000, then 0001. Each done is 10 cycles apart, every match_cnt=0, hit=0.
- Pointer at 1, req=0101 -> grant 0100 (requester 2) before requester 0.
- rst pulsed low at SHIFT bit 4 of a 8'b10011001 job -> immediate IDLE, no done, all outputs 0. A new req0 then completes with match_cnt=2.
- CW=1, data=8'b10011001 -> match_cnt saturates at 1.

Source files
------------

// File: rtl/seq_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | seq_scan_scheduler : 4-way round-robin front end sharing one serial       |
// | Moore "1001" (non-overlapping) detector across requesters.                |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module seq_scan_scheduler #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] req_data,
  output logic [3:0]      gnt,
  output logic            busy,
  output logic            done,
  output logic [1:0]      done_id,
  output logic [CW-1:0]   match_cnt,
  output logic            hit
);

  localparam int BW = $clog2(DW);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [2:0] {D_A, D_B, D_C, D_D, D_E} det_t;

  state_t          state_q, state_d;
  det_t            det_q, det_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [BW-1:0]   bitcnt_q, bitcnt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      done_id_q, done_id_d;
  logic [CW-1:0]   match_cnt_q, match_cnt_d;
  logic            hit_q, hit_d;

  logic            sel_found;
  logic [1:0]      sel_idx;
  logic [1:0]      cand;
  det_t            det_nx;
  logic [CW-1:0]   cnt_nx;

  function automatic det_t det_next(input det_t s, input logic b);
    case (s)
      D_A:     det_next = b ? D_B : D_A;
      D_B:     det_next = b ? D_B : D_C;
      D_C:     det_next = b ? D_B : D_D;
      D_D:     det_next = b ? D_E : D_A;
      D_E:     det_next = b ? D_B : D_A;
      default: det_next = D_A;
    endcase
  endfunction

  always_comb begin
    // Round-robin search starts just after the last granted requester.
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end

    det_nx = det_next(det_q, sr_q[DW-1]);
    cnt_nx = ((det_nx == D_E) && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;

    state_d     = state_q;
    det_d       = det_q;
    sr_d        = sr_q;
    bitcnt_d    = bitcnt_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = 4'b0000;
    busy_d      = busy_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    hit_d       = hit_q;

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          sr_d     = req_data[sel_idx*DW +: DW];
          ptr_d    = sel_idx;
          gnt_d    = 4'b0001 << sel_idx;
          det_d    = D_A;
          cnt_d    = '0;
          bitcnt_d = BW'(DW - 1);
          busy_d   = 1'b1;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d     = sr_q << 1;
        det_d    = det_nx;
        cnt_d    = cnt_nx;
        bitcnt_d = bitcnt_q - 1'b1;
        if (bitcnt_q == '0) begin
          // Result uses cnt_nx so a match completed by the last bit is counted.
          done_d      = 1'b1;
          done_id_d   = ptr_q;
          match_cnt_d = cnt_nx;
          hit_d       = |cnt_nx;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      det_q       <= D_A;
      sr_q        <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      ptr_q       <= 2'd3;
      gnt_q       <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 2'd0;
      match_cnt_q <= '0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      det_q       <= det_d;
      sr_q        <= sr_d;
      bitcnt_q    <= bitcnt_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      hit_q       <= hit_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign hit       = hit_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_seq_scan_scheduler : directed bench for seq_scan_scheduler.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_seq_scan_scheduler;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [4*DW-1:0] req_data;

  logic [3:0]    gnt;
  logic          busy, done, hit;
  logic [1:0]    done_id;
  logic [CW-1:0] match_cnt;

  logic [3:0]    s_gnt;
  logic          s_busy, s_done, s_hit;
  logic [1:0]    s_done_id;
  logic [0:0]    s_match_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  seq_scan_scheduler #(.DW(DW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .match_cnt(match_cnt), .hit(hit)
  );

  // Narrow-counter instance to observe saturation on the same stimulus.
  seq_scan_scheduler #(.DW(DW), .CW(1)) dut_sat (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(s_gnt), .busy(s_busy), .done(s_done), .done_id(s_done_id),
    .match_cnt(s_match_cnt), .hit(s_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request in an IDLE cycle and follow the job to completion.
  task automatic do_job(input string tag, input logic [3:0] r, input logic [3:0] exp_gnt,
                        input logic [1:0] exp_id, input int exp_cnt, input int exp_sat);
    req = r;
    tick();
    check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    req = 4'b0000;
    repeat (DW - 1) tick();
    check({tag, "_early_done"}, 32'(done), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_done_id"}, 32'(done_id), 32'(exp_id));
    check({tag, "_cnt"}, 32'(match_cnt), 32'(exp_cnt));
    check({tag, "_hit"}, 32'(hit), 32'(exp_cnt != 0));
    check({tag, "_sat_cnt"}, 32'(s_match_cnt), 32'(exp_sat));
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_cnt_hold"}, 32'(match_cnt), 32'(exp_cnt));
  endtask

  initial begin
    logic [3:0] g_seen [0:4];
    int         g_time [0:4];
    int         d_time [0:4];
    int         ng;
    int         nd;
    int         stray;

    rst      = 1'b0;
    req      = 4'b1111;
    req_data = '0;
    repeat (2) tick();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);

    // All four requesting from reset: rotation 0,1,2,3,0 at a 10-cycle period.
    rst = 1'b1;
    ng = 0;
    nd = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      tick();
      if (gnt != 4'b0000 && ng < 5) begin
        g_seen[ng] = gnt;
        g_time[ng] = cyc;
        ng++;
      end
      if (done && nd < 5) begin
        d_time[nd] = cyc;
        check("rr_cnt", 32'(match_cnt), 32'd0);
        check("rr_hit", 32'(hit), 32'd0);
        nd++;
      end
      if (cyc == 49) req = 4'b0000;
    end
    check("rr_ngrants", 32'(ng), 32'd5);
    check("rr_ndone", 32'(nd), 32'd5);
    if (ng == 5) begin
      check("rr_g0", 32'(g_seen[0]), 32'h1);
      check("rr_g1", 32'(g_seen[1]), 32'h2);
      check("rr_g2", 32'(g_seen[2]), 32'h4);
      check("rr_g3", 32'(g_seen[3]), 32'h8);
      check("rr_g4", 32'(g_seen[4]), 32'h1);
      check("rr_gt0", 32'(g_time[0]), 32'd1);
      check("rr_gt4", 32'(g_time[4]), 32'd41);
    end
    if (nd == 5) begin
      check("rr_dt0", 32'(d_time[0]), 32'd9);
      for (int i = 1; i < 5; i++)
        check("rr_dspace", 32'(d_time[i] - d_time[i-1]), 32'd10);
    end

    // Two matches; narrow counter saturates at 1.
    req_data[0*DW +: DW] = 8'b10011001;
    do_job("j0", 4'b0001, 4'b0001, 2'd0, 2, 1);

    // Non-overlap: an overlapping detector would report 2.
    req_data[1*DW +: DW] = 8'b10010010;
    do_job("j1", 4'b0010, 4'b0010, 2'd1, 1, 1);

    // Pointer at 1: requester 2 is ahead of requester 0.
    req_data[2*DW +: DW] = 8'b10011001;
    do_job("ptr", 4'b0101, 4'b0100, 2'd2, 2, 1);

    // Abort in the middle of a scan.
    req_data[0*DW +: DW] = 8'b10011001;
    req = 4'b0001;
    tick();
    check("ab_gnt", 32'(gnt), 32'h1);
    req = 4'b0000;
    repeat (3) tick();
    check("ab_busy_pre", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_done", 32'(done), 32'd0);
    check("ab_id", 32'(done_id), 32'd0);
    check("ab_cnt", 32'(match_cnt), 32'd0);
    check("ab_hit", 32'(hit), 32'd0);
    tick();
    rst = 1'b1;
    stray = 0;
    repeat (12) begin
      tick();
      if (done || busy) stray++;
    end
    check("ab_no_done", 32'(stray), 32'd0);
    do_job("ab_rerun", 4'b0001, 4'b0001, 2'd0, 2, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
